// File: rtl/fft_sdf_bfly_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared constants, phase codes and the width-reduction helper
//            used by every radix-2 SDF stage of the 32-point streaming FFT.
// Contents : DW, FRAC             - sample/twiddle width, fractional bits
//            ST_IDLE/FILL/BFLY    - twiddle-ROM phase codes
//            TW_ONE / TW_NEG_ONE  - Q16.8 twiddle constants
//            fft_reduce()         - wrap or saturate a wide value to w bits
// Config   : FFT_STAGE_SAT_EN - when defined, reductions saturate instead
//            of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int DW   = 24;
    localparam int FRAC = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_BFLY = 2'd2;

    localparam logic [DW-1:0] TW_ONE     = 24'h000100;
    localparam logic [DW-1:0] TW_NEG_ONE = 24'hFFFF00;

    // Reduce a sign-extended value to w bits. Callers keep the low w bits
    // of the result, so the wrap variant only needs to mask.
    function automatic logic signed [63:0] fft_reduce(input logic signed [63:0] x,
                                                      input int              w);
`ifdef FFT_STAGE_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
`else
        return x & ((64'sd1 <<< w) - 64'sd1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_sdf_bfly_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_sdf_bfly_stage_if
// Purpose  : Stream/twiddle bundle between a twiddle ROM + previous stage
//            (master) and one SDF butterfly stage (slave).
// Signals  : state[1:0]        phase code from twiddle ROM
//            w_r, w_i          twiddle, Q16.8
//            din_r, din_i      input sample
//            dout_r, dout_i    stage output sample
//            out_valid         dout holds a valid sample
// Revision : 1.0 - initial release
// ============================================================================
interface fft_sdf_bfly_stage_if #(
    parameter int DW = fft_pkg::DW
);
    logic [1:0]    state;
    logic [DW-1:0] w_r;
    logic [DW-1:0] w_i;
    logic [DW-1:0] din_r;
    logic [DW-1:0] din_i;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] dout_i;
    logic          out_valid;

    modport master (
        output state, w_r, w_i, din_r, din_i,
        input  dout_r, dout_i, out_valid
    );

    modport slave (
        input  state, w_r, w_i, din_r, din_i,
        output dout_r, dout_i, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fft_sdf_bfly_stage_cmult.sv
`default_nettype none
// ============================================================================
// Module   : fft_cmult
// Purpose  : Combinational complex multiply (d * w) for the SDF stages.
//            Full-width products, arithmetic shift right by FRAC (floor),
//            then reduction to DW bits via fft_reduce().
// Ports    : i_dr, i_di  in  DW+1  difference operand (signed)
//            i_wr, i_wi  in  DW    twiddle (signed, FRAC fractional bits)
//            o_re, o_im  out DW    reduced product
// Config   : FFT_STAGE_SAT_EN - saturate the reduction instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module fft_cmult
    import fft_pkg::*;
#(
    parameter int DW   = fft_pkg::DW,
    parameter int FRAC = fft_pkg::FRAC
) (
    input  wire logic signed [DW:0]   i_dr,
    input  wire logic signed [DW:0]   i_di,
    input  wire logic signed [DW-1:0] i_wr,
    input  wire logic signed [DW-1:0] i_wi,
    output logic             [DW-1:0] o_re,
    output logic             [DW-1:0] o_im
);

    logic signed [2*DW:0]   w_p_rr;
    logic signed [2*DW:0]   w_p_ii;
    logic signed [2*DW:0]   w_p_ri;
    logic signed [2*DW:0]   w_p_ir;
    logic signed [2*DW+1:0] w_re_full;
    logic signed [2*DW+1:0] w_im_full;
    logic signed [2*DW+1:0] w_re_sh;
    logic signed [2*DW+1:0] w_im_sh;

    assign w_p_rr = i_dr * i_wr;
    assign w_p_ii = i_di * i_wi;
    assign w_p_ri = i_dr * i_wi;
    assign w_p_ir = i_di * i_wr;

    // One extra bit so the sum/difference of two products never overflows.
    assign w_re_full = (2*DW+2)'(w_p_rr) - (2*DW+2)'(w_p_ii);
    assign w_im_full = (2*DW+2)'(w_p_ri) + (2*DW+2)'(w_p_ir);

    assign w_re_sh = w_re_full >>> FRAC;
    assign w_im_sh = w_im_full >>> FRAC;

    assign o_re = DW'(fft_reduce(64'(w_re_sh), DW));
    assign o_im = DW'(fft_reduce(64'(w_im_sh), DW));

endmodule
`default_nettype wire

// File: rtl/fft_sdf_bfly_stage.sv
`default_nettype none
// ============================================================================
// Module   : fft_sdf_bfly_stage
// Purpose  : Radix-2 single-path delay-feedback butterfly stage.
//            fill      : output <= oldest delay entry, delay line <= din
//            butterfly : output <= head + din, delay line <= (head - din) * w
//            idle      : everything holds, out_valid drops
// Ports    : clk        in  1   clock, rising edge
//            rst_n      in  1   asynchronous active-low reset
//            bus        slave   fft_sdf_bfly_stage_if (state, w, din, dout,
//                               out_valid); outputs are registered
// Params   : DELAY - feedback depth in samples (phase half-period)
//            DW    - sample/twiddle width, FRAC - fractional bits
// Config   : FFT_STAGE_SAT_EN - sum and product reductions saturate.
// Revision : 1.0 - initial release
// ============================================================================
module fft_sdf_bfly_stage
    import fft_pkg::*;
#(
    parameter int DELAY = 2,
    parameter int DW    = fft_pkg::DW,
    parameter int FRAC  = fft_pkg::FRAC
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fft_sdf_bfly_stage_if.slave bus
);

    logic [DW-1:0] r_dl_r [DELAY];
    logic [DW-1:0] r_dl_i [DELAY];
    logic [DW-1:0] r_dout_r;
    logic [DW-1:0] r_dout_i;
    logic          r_out_valid;
    logic          r_primed;
    logic          r_last_bfly;   // last shifting phase was a butterfly

    logic              w_fill;
    logic              w_bfly;
    logic              w_shift;
    logic              w_primed;
    logic signed [DW:0] w_head_r;
    logic signed [DW:0] w_head_i;
    logic signed [DW:0] w_din_r;
    logic signed [DW:0] w_din_i;
    logic signed [DW:0] w_sum_r;
    logic signed [DW:0] w_sum_i;
    logic signed [DW:0] w_diff_r;
    logic signed [DW:0] w_diff_i;
    logic [DW-1:0]      w_sum_red_r;
    logic [DW-1:0]      w_sum_red_i;
    logic [DW-1:0]      w_prod_r;
    logic [DW-1:0]      w_prod_i;
    logic [DW-1:0]      w_push_r;
    logic [DW-1:0]      w_push_i;

    assign w_fill  = (bus.state == ST_FILL);
    assign w_bfly  = (bus.state == ST_BFLY);
    assign w_shift = w_fill | w_bfly;

    // A fill that follows a butterfly run releases twiddled differences,
    // so from that point on fill outputs are real data.
    assign w_primed = r_primed | (w_fill & r_last_bfly);

    assign w_head_r = $signed({r_dl_r[0][DW-1], r_dl_r[0]});
    assign w_head_i = $signed({r_dl_i[0][DW-1], r_dl_i[0]});
    assign w_din_r  = $signed({bus.din_r[DW-1], bus.din_r});
    assign w_din_i  = $signed({bus.din_i[DW-1], bus.din_i});

    assign w_sum_r  = w_head_r + w_din_r;
    assign w_sum_i  = w_head_i + w_din_i;
    assign w_diff_r = w_head_r - w_din_r;
    assign w_diff_i = w_head_i - w_din_i;

    assign w_sum_red_r = DW'(fft_reduce(64'(w_sum_r), DW));
    assign w_sum_red_i = DW'(fft_reduce(64'(w_sum_i), DW));

    fft_cmult #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_cmult (
        .i_dr (w_diff_r),
        .i_di (w_diff_i),
        .i_wr ($signed(bus.w_r)),
        .i_wi ($signed(bus.w_i)),
        .o_re (w_prod_r),
        .o_im (w_prod_i)
    );

    assign w_push_r = w_bfly ? w_prod_r : bus.din_r;
    assign w_push_i = w_bfly ? w_prod_i : bus.din_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                r_dl_r[i] <= '0;
                r_dl_i[i] <= '0;
            end
            r_dout_r    <= '0;
            r_dout_i    <= '0;
            r_out_valid <= 1'b0;
            r_primed    <= 1'b0;
            r_last_bfly <= 1'b0;
        end else begin
            if (w_shift) begin
                for (int i = 0; i < DELAY - 1; i++) begin
                    r_dl_r[i] <= r_dl_r[i+1];
                    r_dl_i[i] <= r_dl_i[i+1];
                end
                r_dl_r[DELAY-1] <= w_push_r;
                r_dl_i[DELAY-1] <= w_push_i;
                r_last_bfly     <= w_bfly;
            end

            if (w_fill) begin
                r_dout_r <= r_dl_r[0];
                r_dout_i <= r_dl_i[0];
            end else if (w_bfly) begin
                r_dout_r <= w_sum_red_r;
                r_dout_i <= w_sum_red_i;
            end

            r_out_valid <= w_bfly | (w_fill & w_primed);
            r_primed    <= w_primed;
        end
    end

    assign bus.dout_r    = r_dout_r;
    assign bus.dout_i    = r_dout_i;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire
